// File: rtl/cci_mpf_prim_fifo_reader.sv
// Consumer-side engine for an MPF prim FIFO (first/notEmpty/deq_en). Pops the FIFO head and
// forwards it to a CCI-style channel that flow-controls with almost-full. Adds burst fairness
// gaps, a flush (discard) mode and a wrapping forwarded-word counter.
// Optional simulation checks are compiled in when CCI_MPF_PRIM_FIFO_READER_CHECK_EN is defined.
module cci_mpf_prim_fifo_reader #(
    parameter int unsigned N_DATA_BITS  = 32,
    parameter int unsigned MAX_BURST    = 8,
    parameter int unsigned N_COUNT_BITS = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    flush,
    input  logic [N_DATA_BITS-1:0]  in_first,
    input  logic                    in_notEmpty,
    output logic                    in_deq_en,
    output logic [N_DATA_BITS-1:0]  out_data,
    output logic                    out_valid,
    input  logic                    out_almostFull,
    output logic                    flush_done,
    output logic [N_COUNT_BITS-1:0] out_count
);

    // Burst counter only needs to reach MAX_BURST-1 before it is cleared.
    localparam int unsigned BURST_BITS = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
    localparam int unsigned BURST_LAST_INT = (MAX_BURST == 0) ? 0 : MAX_BURST - 1;
    localparam logic [BURST_BITS-1:0] BURST_LAST = BURST_BITS'(BURST_LAST_INT);
    localparam bit GAP_EN = (MAX_BURST != 0);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StGap,
        StFlush
    } state_e;

    state_e                  state_q, state_d;
    logic                    af_q;
    logic [N_DATA_BITS-1:0]  out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    flush_done_q, flush_done_d;
    logic [N_COUNT_BITS-1:0] count_q, count_d;
    logic [BURST_BITS-1:0]   burst_q, burst_d;
    logic                    deq;

    // Next-state, pop decision and output-register updates.
    always_comb begin
        state_d      = state_q;
        deq          = 1'b0;
        out_data_d   = out_data_q;
        out_valid_d  = 1'b0;
        flush_done_d = 1'b0;
        count_d      = count_q;
        burst_d      = burst_q;

        unique case (state_q)
            StIdle: begin
                burst_d = '0;
                if (flush) begin
                    state_d = StFlush;
                end else if (enable) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // af_q (not the raw input) gates pops; the 2-entry slack absorbs the lag.
                deq = in_notEmpty && !af_q && !flush;
                if (deq) begin
                    out_data_d  = in_first;
                    out_valid_d = 1'b1;
                    count_d     = count_q + N_COUNT_BITS'(1);
                    burst_d     = burst_q + BURST_BITS'(1);
                end else begin
                    burst_d = '0;
                end
                if (flush) begin
                    state_d = StFlush;
                end else if (!enable) begin
                    state_d = StIdle;
                end else if (GAP_EN && deq && (burst_q == BURST_LAST)) begin
                    state_d = StGap;
                    burst_d = '0;
                end
            end
            StGap: begin
                if (flush) begin
                    state_d = StFlush;
                end else if (!enable) begin
                    state_d = StIdle;
                end else begin
                    state_d = StRun;
                end
            end
            StFlush: begin
                // Drain regardless of enable/almost-full; popped words are dropped.
                burst_d = '0;
                deq     = in_notEmpty;
                if (!in_notEmpty) begin
                    flush_done_d = 1'b1;
                    state_d      = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            af_q         <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            flush_done_q <= 1'b0;
            count_q      <= '0;
            burst_q      <= '0;
        end else begin
            state_q      <= state_d;
            af_q         <= out_almostFull;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            flush_done_q <= flush_done_d;
            count_q      <= count_d;
            burst_q      <= burst_d;
        end
    end

    assign in_deq_en  = deq && !reset;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign flush_done = flush_done_q;
    assign out_count  = count_q;

`ifdef CCI_MPF_PRIM_FIFO_READER_CHECK_EN
    // Saturating count of consecutive cycles with almost-full high.
    logic [1:0] af_run_q;

    // Track how long downstream has been almost full.
    always_ff @(posedge clk) begin
        if (reset) begin
            af_run_q <= 2'd0;
        end else if (out_almostFull) begin
            if (af_run_q != 2'd3) begin
                af_run_q <= af_run_q + 2'd1;
            end
        end else begin
            af_run_q <= 2'd0;
        end
    end

    // Protocol sanity checks.
    always @(posedge clk) begin
        if (!reset) begin
            if (in_deq_en && !in_notEmpty) begin
                $fatal(1, "cci_mpf_prim_fifo_reader: in_deq_en while FIFO empty");
            end
            if (out_valid && (af_run_q == 2'd3)) begin
                $fatal(1, "cci_mpf_prim_fifo_reader: out_valid after 3+ cycles of almost-full");
            end
            if ($isunknown(flush)) begin
                $fatal(1, "cci_mpf_prim_fifo_reader: flush is X/Z");
            end
        end
    end
`endif

endmodule

// File: tb/tb_cci_mpf_prim_fifo_reader.sv
// Bench for cci_mpf_prim_fifo_reader: a queue-based FIFO model feeds the DUT, a scoreboard
// collects every forwarded pop and a negedge monitor checks outputs and flow-control rules.
module tb_cci_mpf_prim_fifo_reader;

    localparam int unsigned DW = 32;
    localparam int unsigned MB = 4;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          flush;
    logic [DW-1:0] in_first;
    logic          in_notEmpty;
    logic          in_deq_en;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_almostFull;
    logic          flush_done;
    logic [CW-1:0] out_count;

    cci_mpf_prim_fifo_reader #(
        .N_DATA_BITS  (DW),
        .MAX_BURST    (MB),
        .N_COUNT_BITS (CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .flush          (flush),
        .in_first       (in_first),
        .in_notEmpty    (in_notEmpty),
        .in_deq_en      (in_deq_en),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_almostFull (out_almostFull),
        .flush_done     (flush_done),
        .out_count      (out_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    bit            discard_mode = 1'b0;
    bit            exp_valid    = 1'b0;
    logic [CW-1:0] exp_count    = '0;
    bit            af_prev      = 1'b0;
    bit            rst_prev     = 1'b1;
    int            run_len      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h time=%0t", name, act, req, $time);
        end
    endtask

    task automatic refresh();
        in_notEmpty = (fifo_q.size() > 0);
        in_first    = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    endtask

    task automatic push(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        refresh();
    endtask

    // One clock cycle: sample pop/flush_done mid-cycle, then apply the pop after the edge.
    task automatic step(output bit deq_s, output bit fd_s);
        @(negedge clk);
        deq_s = (in_deq_en === 1'b1);
        fd_s  = (flush_done === 1'b1);
        @(posedge clk);
        #1;
        if (deq_s && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
        end
        refresh();
    endtask

    task automatic cyc(input string tag, input int idx, input bit req_deq, input bit req_fd);
        bit d;
        bit f;
        step(d, f);
        check($sformatf("%s_deq[%0d]", tag, idx), 64'(d), 64'(req_deq));
        check($sformatf("%s_fd[%0d]", tag, idx), 64'(f), 64'(req_fd));
    endtask

    task automatic idle_steps(input int n);
        bit d;
        bit f;
        for (int i = 0; i < n; i++) begin
            step(d, f);
        end
    endtask

    // Scoreboard/monitor: out_valid must follow each forwarded pop by exactly one cycle.
    initial begin
        forever begin
            @(negedge clk);
            check("out_valid", 64'(out_valid), 64'(exp_valid));
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("out_data_unexpected", 64'(out_data), 64'hdead_0000);
                end else begin
                    check("out_data", 64'(out_data), 64'(exp_q.pop_front()));
                end
            end
            check("out_count", 64'(out_count), 64'(exp_count));
            if (in_deq_en === 1'b1) begin
                check("deq_nonempty", 64'(in_notEmpty), 64'd1);
                if (reset) check("deq_in_reset", 64'(in_deq_en), 64'd0);
                if (!discard_mode && !reset) begin
                    check("deq_after_af", 64'(af_prev && !rst_prev), 64'd0);
                end
            end
            if (in_deq_en === 1'b1 && !discard_mode) run_len++;
            else run_len = 0;
            if (run_len > 0) check("burst_len", 64'(run_len <= int'(MB)), 64'd1);
            begin
                bit fwd;
                fwd = (in_deq_en === 1'b1) && !discard_mode && !reset;
                if (fwd) exp_q.push_back(in_first);
                exp_valid = fwd;
                exp_count = reset ? '0 : exp_count + CW'(fwd);
            end
            af_prev  = out_almostFull;
            rst_prev = reset;
        end
    end

    initial begin
        bit d;
        bit f;
        bit req[$];
        int rem;
        reset          = 1'b1;
        enable         = 1'b0;
        flush          = 1'b0;
        out_almostFull = 1'b0;
        refresh();
        idle_steps(3);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(out_count), 64'd0);
        check("rst_fd", 64'(flush_done), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        reset = 1'b0;
        idle_steps(1);

        // Three words back to back.
        push(32'hA); push(32'hB); push(32'hC);
        enable = 1'b1;
        cyc("t1", 0, 0, 0);
        for (int i = 1; i <= 3; i++) cyc("t1", i, 1, 0);
        cyc("t1", 4, 0, 0);
        cyc("t1", 5, 0, 0);
        check("t1_count", 64'(out_count), 64'd3);
        enable = 1'b0;
        idle_steps(2);

        // Ten words with burst gaps: MB words, one idle, ...
        for (int i = 0; i < 10; i++) push(32'h100 + 32'(i));
        enable = 1'b1;
        req.delete();
        req.push_back(1'b0);
        rem = 10;
        while (rem > 0) begin
            int k;
            k = (rem < int'(MB)) ? rem : int'(MB);
            for (int j = 0; j < k; j++) req.push_back(1'b1);
            req.push_back(1'b0);
            rem -= k;
        end
        while (req.size() < 16) req.push_back(1'b0);
        for (int i = 0; i < 16; i++) cyc("t2", i, req[i], 0);
        check("t2_count", 64'(out_count), 64'd13);
        enable = 1'b0;
        idle_steps(2);

        // Almost-full asserted for cycles 2..6 of a stream.
        for (int i = 0; i < 12; i++) push(32'h200 + 32'(i));
        enable = 1'b1;
        req.delete();
        req = '{0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1};
        for (int i = 0; i < 12; i++) begin
            out_almostFull = (i >= 2 && i <= 6);
            cyc("t3", i, req[i], 0);
        end
        out_almostFull = 1'b0;
        idle_steps(20);
        check("t3_count", 64'(out_count), 64'd25);
        check("t3_empty", 64'(fifo_q.size()), 64'd0);
        enable = 1'b0;
        idle_steps(2);

        // Flush with an empty FIFO.
        flush        = 1'b1;
        discard_mode = 1'b1;
        cyc("t5", 0, 0, 0);
        flush = 1'b0;
        cyc("t5", 1, 0, 0);
        cyc("t5", 2, 0, 1);
        cyc("t5", 3, 0, 0);
        cyc("t5", 4, 0, 0);

        // Flush five queued words while disabled.
        for (int i = 0; i < 5; i++) push(32'h300 + 32'(i));
        flush = 1'b1;
        cyc("t4", 0, 0, 0);
        flush = 1'b0;
        for (int i = 1; i <= 5; i++) cyc("t4", i, 1, 0);
        cyc("t4", 6, 0, 0);
        cyc("t4", 7, 0, 1);
        cyc("t4", 8, 0, 0);
        cyc("t4", 9, 0, 0);
        discard_mode = 1'b0;
        check("t4_count", 64'(out_count), 64'd25);
        check("t4_empty", 64'(fifo_q.size()), 64'd0);
        push(32'h400);
        for (int i = 0; i < 3; i++) cyc("t4_idle", i, 0, 0);

        // Reset mid-stream, then restart from the current head.
        for (int i = 1; i <= 5; i++) push(32'h400 + 32'(i));
        enable = 1'b1;
        cyc("t6", 0, 0, 0);
        cyc("t6", 1, 1, 0);
        reset = 1'b1;
        cyc("t6", 2, 0, 0);
        check("t6_valid_clr", 64'(out_valid), 64'd0);
        check("t6_count_clr", 64'(out_count), 64'd0);
        reset = 1'b0;
        cyc("t6", 3, 0, 0);
        cyc("t6", 4, 1, 0);
        idle_steps(10);
        check("t6_count", 64'(out_count), 64'd5);
        check("t6_empty", 64'(fifo_q.size()), 64'd0);

        // Random traffic with random almost-full.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) < 45 && fifo_q.size() < 16) push($urandom);
            if ($urandom_range(0, 9) == 0) out_almostFull = ~out_almostFull;
            step(d, f);
        end
        out_almostFull = 1'b0;
        for (int i = 0; i < 200 && (fifo_q.size() > 0 || exp_q.size() > 0); i++) step(d, f);
        idle_steps(2);
        check("rand_fifo_drained", 64'(fifo_q.size()), 64'd0);
        check("rand_sb_drained", 64'(exp_q.size()), 64'd0);
        enable = 1'b0;
        idle_steps(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
